// File: rtl/mod_rate_pkg.sv
// Shared types and constants for the modulator symbol-rate controller.
package mod_rate_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Divider value in force after reset (tick period = DEF_DIV + 1 cycles).
  localparam int DEF_DIV = 7;

endpackage

// File: rtl/rate_tick_counter.sv
// Loadable down-counter: loads on demand, otherwise counts down while running
// and reloads itself from reload_val when it reaches zero.
module rate_tick_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] reload_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  assign expire = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_val;
    end else if (run) begin
      cnt <= expire ? reload_val : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mod_rate_ctrl.sv
// Symbol-rate controller: emits a one-cycle tick every DIV+1 cycles during a burst,
// with divider updates taken by handshake and applied only on tick boundaries.
module mod_rate_ctrl
  import mod_rate_pkg::*;
#(
  parameter int NBITS       = 3,
  parameter int LBITS       = 8,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] i_cfg_div,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [LBITS-1:0] i_burst_len,
  output logic             o_tick,
  output logic [LBITS-1:0] o_sym_idx,
  output logic             o_busy,
  output logic             o_done
);

  state_t           state, state_next;
  logic             tick, tick_next;
  logic             done, done_next;
  logic             last, last_next;
  logic [LBITS-1:0] idx, idx_next, idx_inc;
  logic [LBITS-1:0] len, len_next;
  logic [NBITS-1:0] div, shadow, reload_val;
  logic             pending;
  logic             expire, load, final_reload, accept, exiting;

  assign idx_inc      = idx + 1'b1;
  assign final_reload = expire && (len != '0) && (idx_inc == len);
  assign load         = (state == ST_IDLE) && i_start && !i_stop;
  assign reload_val   = ((state == ST_RUN) && pending) ? shadow : div;
  assign o_cfg_ready  = (state == ST_IDLE) || !pending;
  assign accept       = i_cfg_valid && o_cfg_ready;
  assign exiting      = (state == ST_RUN) && (state_next == ST_IDLE);

  rate_tick_counter #(.W(NBITS)) u_cnt (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (load),
    .run        (state == ST_RUN),
    .reload_val (reload_val),
    .expire     (expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      tick  <= 1'b0;
      done  <= 1'b0;
      last  <= 1'b0;
      idx   <= '0;
      len   <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      done  <= done_next;
      last  <= last_next;
      idx   <= idx_next;
      len   <= len_next;
    end
  end

  // The final reload wins over a coincident stop so the last symbol is never cut short.
  always_comb begin
    state_next = state;
    tick_next  = 1'b0;
    done_next  = 1'b0;
    last_next  = 1'b0;
    idx_next   = idx;
    len_next   = len;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          state_next = ST_RUN;
          idx_next   = '0;
          len_next   = i_burst_len;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (i_stop && !final_reload) begin
          state_next = ST_IDLE;
        end else if (expire) begin
          tick_next = 1'b1;
          idx_next  = idx_inc;
          last_next = final_reload;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Active divider and shadow; a value still pending at burst exit is committed then.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div     <= NBITS'(DEFAULT_DIV);
      shadow  <= '0;
      pending <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) div <= i_cfg_div;
    end else if (exiting) begin
      if (accept)       div <= i_cfg_div;
      else if (pending) div <= shadow;
      pending <= 1'b0;
    end else begin
      if (expire && pending) begin
        div     <= shadow;
        pending <= 1'b0;
      end
      if (accept) begin
        shadow  <= i_cfg_div;
        pending <= 1'b1;
      end
    end
  end

  assign o_tick    = tick;
  assign o_done    = done;
  assign o_sym_idx = idx;
  assign o_busy    = (state == ST_RUN);

endmodule

// File: tb/tb_mod_rate_ctrl.sv
// Scoreboard bench for mod_rate_ctrl: expected tick/done events are queued by the
// stimulus and popped by an independent monitor whenever the DUT strobes.
module tb_mod_rate_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [2:0] i_cfg_div = '0;
  logic       i_cfg_valid = 1'b0;
  logic       o_cfg_ready;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [7:0] i_burst_len = '0;
  logic       o_tick;
  logic [7:0] o_sym_idx;
  logic       o_busy;
  logic       o_done;

  mod_rate_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cfg_div   (i_cfg_div),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_burst_len (i_burst_len),
    .o_tick      (o_tick),
    .o_sym_idx   (o_sym_idx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int at;
    int idx;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push_tick(input int at, input int idx);
    exp_q.push_back('{is_done: 1'b0, at: at, idx: idx});
  endtask

  task automatic push_done(input int at);
    exp_q.push_back('{is_done: 1'b1, at: at, idx: 0});
  endtask

  task automatic cfg_idle(input logic [2:0] d);
    i_cfg_div   = d;
    i_cfg_valid = 1'b1;
    check("cfg_ready_idle", int'(o_cfg_ready), 1);
    step(1);
    i_cfg_valid = 1'b0;
  endtask

  // Issues a start; returns the cycle number of the edge that sampled it.
  task automatic start_burst(input logic [7:0] len, output int t0);
    i_start     = 1'b1;
    i_burst_len = len;
    step(1);
    i_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic push_burst(input int t0, input int per, input int len);
    for (int k = 1; k <= len; k++) push_tick(t0 + k * per, k % 256);
    push_done(t0 + len * per + 1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_tick || o_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: tick=%0d done=%0d idx=%0d, expected none (cycle %0d)",
                 o_tick, o_done, o_sym_idx, cyc);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("event_kind_done", int'(o_done), int'(e.is_done));
        check("event_cycle", cyc, e.at);
        if (!e.is_done) check("tick_sym_idx", int'(o_sym_idx), e.idx);
      end
    end
  end

  initial begin
    int t0;

    step(3);
    i_rst = 1'b0;
    step(1);
    check("rst_tick", int'(o_tick), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_idx", int'(o_sym_idx), 0);
    check("rst_ready", int'(o_cfg_ready), 1);

    // Default divider 7, four symbols.
    start_burst(8'd4, t0);
    push_burst(t0, 8, 4);
    check("t1_busy", int'(o_busy), 1);
    step(36);
    check("t1_idle", int'(o_busy), 0);

    // Divider 2 programmed in IDLE; ready must stay high throughout.
    cfg_idle(3'd2);
    start_burst(8'd3, t0);
    push_burst(t0, 3, 3);
    step(4);
    check("t2_ready_run", int'(o_cfg_ready), 1);
    step(8);

    // Mid-period change from 7 to 1 is deferred to the next reload.
    cfg_idle(3'd7);
    start_burst(8'd4, t0);
    push_tick(t0 + 8, 1);
    push_tick(t0 + 10, 2);
    push_tick(t0 + 12, 3);
    push_tick(t0 + 14, 4);
    push_done(t0 + 15);
    step(3);
    i_cfg_div   = 3'd1;
    i_cfg_valid = 1'b1;
    check("t3_ready_before", int'(o_cfg_ready), 1);
    step(1);
    i_cfg_valid = 1'b0;
    check("t3_ready_pending", int'(o_cfg_ready), 0);
    step(5);
    check("t3_ready_after_reload", int'(o_cfg_ready), 1);
    step(10);

    // Continuous mode at divider 0: index wraps, stop ends it without done.
    cfg_idle(3'd0);
    start_burst(8'd0, t0);
    for (int k = 1; k <= 260; k++) push_tick(t0 + k, k % 256);
    step(260);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    check("t4_tick_after_stop", int'(o_tick), 0);
    check("t4_busy_after_stop", int'(o_busy), 0);
    check("t4_done_after_stop", int'(o_done), 0);
    step(3);

    // Stop coinciding with the final reload still yields last tick and done.
    cfg_idle(3'd3);
    start_burst(8'd2, t0);
    push_burst(t0, 4, 2);
    step(7);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    step(4);
    check("t5_idle_after_done", int'(o_busy), 0);
    i_start = 1'b1;
    i_stop  = 1'b1;
    step(1);
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("t5_start_stop_idle", int'(o_busy), 0);
    step(10);

    // Reset mid-burst with a pending divider: everything returns to defaults.
    start_burst(8'd5, t0);
    push_tick(t0 + 4, 1);
    step(4);
    i_cfg_div   = 3'd5;
    i_cfg_valid = 1'b1;
    step(1);
    i_cfg_valid = 1'b0;
    check("t6_pending_ready", int'(o_cfg_ready), 0);
    #2 i_rst = 1'b1;
    #1;
    check("t6_rst_busy", int'(o_busy), 0);
    check("t6_rst_idx", int'(o_sym_idx), 0);
    check("t6_rst_tick", int'(o_tick), 0);
    check("t6_rst_ready", int'(o_cfg_ready), 1);
    step(2);
    i_rst = 1'b0;
    step(1);
    start_burst(8'd2, t0);
    push_burst(t0, 8, 2);
    step(20);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
